clock_gate_ctrl: RTL

//  Multi-channel clock-gate controller: derives NCH gated clocks from aclk, each with its
//  own pause state set by an explicit request edge or by an idle timeout, and cleared by an

---
 rtl/clock_gate_ctrl_pkg.sv | 23 ++
 rtl/clock_gate_ctrl_cell.sv | 20 ++
 rtl/clock_gate_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and helpers for the multi-channel clock-gate controller.
package clock_gate_pkg;

  // Per-channel gating state: running, paused, or in the post-wake hold-off window.
  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_GATED = 2'd1,
    CG_WAKE  = 2'd2
  } cg_state_e;

  localparam int unsigned WAKE_CYCLES_DEFAULT = 2;

  // Width of the wake hold-off counter, i.e. $clog2(WAKE_CYCLES+1).
  // The result is kept at least 1 bit wide.
  function automatic int unsigned wake_w(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned WAKE_W = wake_w(WAKE_CYCLES_DEFAULT);

endpackage

// File: rtl/clock_gate_ctrl_cell.sv
// Glitch-free clock gate: a low-transparent latch followed by an AND.
// The latch is the only non-flop storage in the controller.
// It needs an STA/lint waiver as an intentional latch.
module clock_gate_cell (
  input  logic aclk_i,
  input  logic pause_i,
  output logic gclk_o
);

  logic pause_l;

  // Capture the pause request only while aclk is low.
  // The enable is therefore frozen for the whole high phase, so no runt pulse can occur.
  always_latch begin
    if (!aclk_i) pause_l <= pause_i;
  end

  assign gclk_o = aclk_i & ~pause_l;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Multi-channel clock-gate controller.
// Each channel pauses on a clear_clock_gate rising edge or on an idle timeout.
// It resumes on set_clock_gate or on busy activity, after a short hold-off window.
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned IDLE_W      = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter bit          AUTO_WAKE   = 1'b1
) (
  input  logic              aclk,
  input  logic              resetn,
  output logic [NCH-1:0]    clk,
  input  logic [NCH-1:0]    clear_clock_gate,
  input  logic [NCH-1:0]    set_clock_gate,
  input  logic [NCH-1:0]    busy,
  input  logic [IDLE_W-1:0] idle_limit,
  input  logic              force_on,
  output logic [NCH-1:0]    gated
);

  localparam int unsigned         HOLD_W    = wake_w(WAKE_CYCLES);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(WAKE_CYCLES - 1);
  localparam logic [IDLE_W-1:0]   IDLE_ONE  = IDLE_W'(1);

  logic [NCH-1:0] clear_last_q;
  logic [NCH-1:0] clr_ps;

  assign clr_ps = clear_clock_gate & ~clear_last_q;

  // Edge history keeps tracking while force_on is high.
  // A clear that is still held when force_on drops therefore does not fire.
  always_ff @(posedge aclk) begin
    if (!resetn) clear_last_q <= '0;
    else         clear_last_q <= clear_clock_gate;
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    cg_state_e          state_q, state_d;
    logic [IDLE_W-1:0]  idle_q,  idle_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;

    // Next-state logic.
    // An explicit request edge beats a same-cycle release.
    // The idle compare is an equality against the live limit.
    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      hold_d  = hold_q;
      if (force_on) begin
        state_d = CG_RUN;
        idle_d  = '0;
        hold_d  = '0;
      end else begin
        unique case (state_q)
          CG_RUN: begin
            if (clr_ps[gi]) begin
              state_d = CG_GATED;
              idle_d  = '0;
            end else if (idle_limit != '0 && idle_q == idle_limit) begin
              state_d = CG_GATED;
              idle_d  = '0;
            end else if (busy[gi]) begin
              idle_d  = '0;
            end else if (idle_q != '1) begin
              idle_d  = idle_q + IDLE_ONE;
            end
          end
          CG_GATED: begin
            idle_d = '0;
            if (set_clock_gate[gi] || (AUTO_WAKE && busy[gi])) begin
              state_d = CG_WAKE;
              hold_d  = '0;
            end
          end
          CG_WAKE: begin
            idle_d = '0;
            if (clr_ps[gi]) begin
              state_d = CG_GATED;
              hold_d  = '0;
            end else if (hold_q == HOLD_LAST) begin
              state_d = CG_RUN;
              hold_d  = '0;
            end else begin
              hold_d  = hold_q + HOLD_W'(1);
            end
          end
          default: begin
            state_d = CG_RUN;
            idle_d  = '0;
            hold_d  = '0;
          end
        endcase
      end
    end

    // State and counter registers.
    // Reset returns the channel to RUN with its clock running.
    always_ff @(posedge aclk) begin
      if (!resetn) begin
        state_q <= CG_RUN;
        idle_q  <= '0;
        hold_q  <= '0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        hold_q  <= hold_d;
      end
    end

    assign gated[gi] = (state_q == CG_GATED);

    clock_gate_cell u_cell (
      .aclk_i  (aclk),
      .pause_i (gated[gi]),
      .gclk_o  (clk[gi])
    );
  end

endmodule
